vout_stream_timing: RTL

Video output timing generator and pixel pacer for the HDMI transmit path. It produces the raster timing (`vout_hs`/`vout_vs`/`vout_de`) and pulls one 24-bit pixel per active cycle from an upstream valid/ready stream that carries a start-of-frame marker. It drives the `vout_*` pins of the ADV7511 and replaces the block-design video source. It runs in the pixel clock domain, independent of the I2C configuration path.

---
 rtl/hdmi_timing_pkg.sv | 34 +++
 rtl/vout_stream_timing_raster_counter.sv | 73 +++++++
 rtl/vout_stream_timing.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared raster timing sets, derived totals and the pacer state encoding
// for the HDMI video output path.
package hdmi_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  localparam timing_t TIMING_1080P60 = '{1920, 88, 44, 148, 1080, 4, 5, 36};
  localparam timing_t TIMING_720P60  = '{1280, 110, 40, 220, 720, 5, 5, 20};
  localparam timing_t TIMING_480P    = '{640, 16, 96, 48, 480, 10, 2, 33};

  function automatic int unsigned h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/vout_stream_timing_raster_counter.sv
// Horizontal/vertical raster counters with active, sync and first-pixel decode.
// Counters sit at zero whenever run_i is low.
module raster_counter
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = TIMING_1080P60.h_active,
  parameter int unsigned H_FP     = TIMING_1080P60.h_fp,
  parameter int unsigned H_SYNC   = TIMING_1080P60.h_sync,
  parameter int unsigned H_BP     = TIMING_1080P60.h_bp,
  parameter int unsigned V_ACTIVE = TIMING_1080P60.v_active,
  parameter int unsigned V_FP     = TIMING_1080P60.v_fp,
  parameter int unsigned V_SYNC   = TIMING_1080P60.v_sync,
  parameter int unsigned V_BP     = TIMING_1080P60.v_bp
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic act_o,
  output logic first_o,
  output logic hs_o,
  output logic vs_o
);

  localparam timing_t     CFG     = '{H_ACTIVE, H_FP, H_SYNC, H_BP,
                                      V_ACTIVE, V_FP, V_SYNC, V_BP};
  localparam int unsigned H_TOTAL = h_total(CFG);
  localparam int unsigned V_TOTAL = v_total(CFG);
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // vs decodes from v only, so it can only move when h wraps to 0
  assign act_o   = (h_q < H_ACT) && (v_q < V_ACT);
  assign first_o = (h_q == '0) && (v_q == '0);
  assign hs_o    = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_o    = (v_q >= VS_BEG) && (v_q < VS_END);

endmodule

// File: rtl/vout_stream_timing.sv
// HDMI output timing generator and pixel pacer: raster timing plus a
// valid/ready pixel pull locked to the stream's start-of-frame marker.
module vout_stream_timing
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = TIMING_1080P60.h_active,
  parameter int unsigned H_FP     = TIMING_1080P60.h_fp,
  parameter int unsigned H_SYNC   = TIMING_1080P60.h_sync,
  parameter int unsigned H_BP     = TIMING_1080P60.h_bp,
  parameter int unsigned V_ACTIVE = TIMING_1080P60.v_active,
  parameter int unsigned V_FP     = TIMING_1080P60.v_fp,
  parameter int unsigned V_SYNC   = TIMING_1080P60.v_sync,
  parameter int unsigned V_BP     = TIMING_1080P60.v_bp,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic              vout_hs,
  output logic              vout_vs,
  output logic              vout_de,
  output logic [DATA_W-1:0] vout_data,
  output logic              frame_start,
  output logic              underflow,
  output logic              sync_err
);

  state_t state_q, state_d;
  logic   act, first, hs_raw, vs_raw;
  logic   sof_lock, sof_bad;

  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fs_q, fs_d, uf_q, uf_d, se_q, se_d;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .run_i   (en && (state_q != ST_IDLE)),
    .act_o   (act),
    .first_o (first),
    .hs_o    (hs_raw),
    .vs_o    (vs_raw)
  );

  // SOF lands on the first active pixel (lock) or a word's SOF flag disagrees with its position
  assign sof_lock = act && first && s_valid && s_sof;
  assign sof_bad  = act && s_valid && (s_sof != first);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_RESYNC;
        ST_RESYNC: if (sof_lock) state_d = ST_RUN;
        ST_RUN:    if (sof_bad) state_d = ST_RESYNC;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = 1'b0;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    de_d    = 1'b0;
    data_d  = '0;
    fs_d    = 1'b0;
    uf_d    = uf_q;
    se_d    = se_q;
    if (state_q != ST_IDLE) begin
      hs_d = hs_raw ? HS_POL : ~HS_POL;
      vs_d = vs_raw ? VS_POL : ~VS_POL;
    end
    case (state_q)
      ST_RESYNC: begin
        // non-SOF words drain; an SOF waits for the first active pixel
        s_ready = s_valid && (!s_sof || (act && first));
        if (sof_lock) begin
          de_d   = 1'b1;
          data_d = s_data;
          fs_d   = 1'b1;
        end
      end
      ST_RUN: begin
        s_ready = act;
        if (act) begin
          de_d = 1'b1;
          fs_d = first;
          if (!s_valid)    uf_d   = 1'b1;
          else if (sof_bad) se_d  = 1'b1;
          else             data_d = s_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      data_q <= '0;
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      data_q <= data_d;
      fs_q   <= fs_d;
      uf_q   <= uf_d;
      se_q   <= se_d;
    end
  end

  assign vout_hs     = hs_q;
  assign vout_vs     = vs_q;
  assign vout_de     = de_q;
  assign vout_data   = data_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign sync_err    = se_q;

endmodule
